pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Fetch-stage controller that owns the program counter.
- Sequences instruction-memory requests over a req/ack handshake.
- Applies stall from decode and redirects (branch/jump) from execute.
- Presents one fetched instruction at a time to decode, and emits a flush pulse when the front end is redirected.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0080, target used for misaligned redirects (PC_TRAP_EN only)
PC_INC, 4, sequential PC increment in bytes

Ports:
clk_i  input  1  clock; all state updates on posedge
rst_i  input  1  reset, asynchronous, active-low
stall_i  input  1  decode cannot accept the held instruction
redirect_i  input  1  execute resolves a taken branch or jump this cycle
redirect_pc_i  input  32  redirect target, sampled when redirect_i=1
imem_req_o  output  1  instruction memory request
imem_addr_o  output  32  request address; stable while imem_req_o=1 and no ack
imem_ack_i  input  1  memory completion; imem_data_i valid in the same cycle
imem_data_i  input  32  instruction word
inst_o  output  32  instruction word to decode
inst_pc_o  output  32  address of inst_o
inst_valid_o  output  1  inst_o/inst_pc_o valid
flush_o  output  1  one-cycle pulse: younger pipeline work must be killed
trap_o  output  1  one-cycle misaligned-redirect pulse (tied 0 without PC_TRAP_EN)

Behaviour:
- Reset (rst_i=0, asynchronous):
  - pc=RESET_PC and state=S_BOOT.
  - imem_req_o, inst_valid_o, flush_o and trap_o are 0.
  - inst_o, inst_pc_o and imem_addr_o are 0.
  - Outputs change immediately, not at the next clock edge.
- States: S_BOOT, S_FETCH, S_VALID, S_DRAIN. All outputs are registered.
- S_BOOT:
  - One cycle, then S_FETCH.
  - On that edge, imem_addr_o<=pc and imem_req_o<=1.
- S_FETCH:
  - imem_req_o and imem_addr_o are held until imem_ack_i.
  - On ack: inst_o<=imem_data_i, inst_pc_o<=imem_addr_o, inst_valid_o<=1, pc<=pc+PC_INC, imem_req_o<=0, then S_VALID.
- S_VALID:
  - inst_o, inst_pc_o and inst_valid_o are held while stall_i=1.
  - When stall_i=0 (instruction consumed): inst_valid_o<=0, imem_req_o<=1, imem_addr_o<=pc, then S_FETCH.
  - Throughput: one instruction every 2 cycles with a zero-wait memory.
- Redirect priority:
  - redirect_i beats stall_i and ack in every state.
  - Each accepted redirect gives flush_o=1 on the following cycle.
- Redirect by state:
  - S_BOOT / S_VALID: inst_valid_o<=0, pc<=target, fetch of target starts (S_FETCH, req=1, addr=target).
  - S_FETCH with ack in the same cycle: the data is discarded (inst_valid_o stays 0) and the fetch of target starts.
  - S_FETCH without ack: the request cannot be cancelled. pc<=target; S_DRAIN.
  - S_DRAIN: req and the old address are held until ack, the data is discarded, then the fetch of pc starts.
- Redirect while in S_DRAIN: pc is overwritten (latest target wins) and flush_o pulses again.
- PC arithmetic: unsigned modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- imem_ack_i outside S_FETCH/S_DRAIN is ignored.
- Reset mid-fetch drops imem_req_o at once; the memory must tolerate an abandoned request.

Optional Feature:
- Macro: PC_SEQUENCER_PC_TRAP_EN.
- Defined: a redirect with redirect_pc_i[1:0]!=0 loads TRAP_VEC instead of the target; trap_o pulses together with flush_o.
- Undefined: the target's low 2 bits are forced to 0 and trap_o is constant 0.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum pc_seq_state_t (S_BOOT, S_FETCH, S_VALID, S_DRAIN);
  - default constants PC_RESET_DEFAULT, PC_TRAP_VEC_DEFAULT, PC_INC_DEFAULT.
- One sub-module, pc_next_sel: combinational next-PC select (sequential / redirect / trap-vector / hold), including the alignment check.

Test Plan:
- Zero-wait ack every request after reset, no stall -> inst_pc_o sequence 0,4,8,C with inst_valid_o high every other cycle.
- Ack delayed 3 cycles -> imem_addr_o and imem_req_o stable across those cycles; single inst_valid_o at addr 0.
- stall_i=1 for 4 cycles in S_VALID (inst 0x00000013 @0x8) -> outputs unchanged, no new request, fetch of 0xC starts the cycle after release.
- redirect_i (target 0x100) in S_FETCH with ack 2 cycles later -> flush_o pulse, stale data dropped, next req addr 0x100, next inst_pc_o 0x100.
- Simultaneous redirect and stall in S_VALID -> redirect taken, valid drops, fetch of the target; wrap test RESET_PC=0xFFFFFFFC -> second fetch at 0x0.
- With PC_SEQUENCER_PC_TRAP_EN, redirect to 0x102 -> trap_o and flush_o pulse, next fetch at 0x80; without the macro -> fetch at 0x100, trap_o stays 0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared FSM state type and default constants for the pc_sequencer fetch controller.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_DRAIN = 2'd3
    } pc_seq_state_t;

    localparam logic [31:0] PC_RESET_DEFAULT    = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VEC_DEFAULT = 32'h0000_0080;
    localparam logic [31:0] PC_INC_DEFAULT      = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-stage bus bundle: decode/execute control, instruction memory handshake, decode output.
interface pc_sequencer_if;

    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        flush_o;
    logic        trap_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_ack_i, imem_data_i,
        output imem_req_o, imem_addr_o, inst_o, inst_pc_o, inst_valid_o, flush_o, trap_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_ack_i, imem_data_i,
        input  imem_req_o, imem_addr_o, inst_o, inst_pc_o, inst_valid_o, flush_o, trap_o
    );

endinterface

// File: rtl/pc_sequencer_next_sel.sv
// Combinational next-PC select (redirect / trap vector / sequential / hold).
// Misaligned-redirect trapping is enabled by defining PC_SEQUENCER_PC_TRAP_EN.
module pc_next_sel import pc_seq_pkg::*; #(
    parameter logic [31:0] TRAP_VEC = PC_TRAP_VEC_DEFAULT,
    parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic [31:0] i_pc,
    input  logic        i_advance,
    input  logic        i_redirect,
    input  logic [31:0] i_redirectPc,
    output logic [31:0] o_nextPc,
    output logic [31:0] o_target,
    output logic        o_trap
);

    logic        w_misaligned;
    logic [31:0] w_alignedPc;

`ifdef PC_SEQUENCER_PC_TRAP_EN
    assign w_misaligned = (i_redirectPc[1:0] != 2'b00);
    assign w_alignedPc  = i_redirectPc;
`else
    // Without trapping, a misaligned target is silently rounded down to a word boundary.
    assign w_misaligned = 1'b0;
    assign w_alignedPc  = i_redirectPc & 32'hFFFF_FFFC;
`endif

    assign o_target = w_misaligned ? TRAP_VEC : w_alignedPc;
    assign o_trap   = i_redirect & w_misaligned;

    always_comb begin
        o_nextPc = i_pc;
        if (i_redirect) begin
            o_nextPc = o_target;
        end else if (i_advance) begin
            o_nextPc = i_pc + PC_INC;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller owning the PC: sequences imem requests, handles stall and redirects.
// Optional feature macro: PC_SEQUENCER_PC_TRAP_EN (misaligned redirect -> TRAP_VEC + trap_o pulse).
module pc_sequencer import pc_seq_pkg::*; #(
    parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
    parameter logic [31:0] TRAP_VEC = PC_TRAP_VEC_DEFAULT,
    parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pc_sequencer_if.master bus
);

    pc_seq_state_t r_state;
    pc_seq_state_t w_stateNext;

    logic [31:0] r_pc;
    logic [31:0] w_nextPc;
    logic [31:0] w_target;
    logic        w_trap;
    logic        w_advance;

    logic        r_req,    w_reqNext;
    logic [31:0] r_addr,   w_addrNext;
    logic [31:0] r_inst,   w_instNext;
    logic [31:0] r_instPc, w_instPcNext;
    logic        r_valid,  w_validNext;
    logic        r_flush;
    logic        r_trap;

    assign w_advance = (r_state == S_FETCH) && bus.imem_ack_i && !bus.redirect_i;

    pc_next_sel #(
        .TRAP_VEC (TRAP_VEC),
        .PC_INC   (PC_INC)
    ) u_nextSel (
        .i_pc         (r_pc),
        .i_advance    (w_advance),
        .i_redirect   (bus.redirect_i),
        .i_redirectPc (bus.redirect_pc_i),
        .o_nextPc     (w_nextPc),
        .o_target     (w_target),
        .o_trap       (w_trap)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // An in-flight request cannot be cancelled, so a redirect without ack parks in S_DRAIN.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_BOOT:  w_stateNext = S_FETCH;
            S_FETCH: begin
                if (bus.redirect_i) begin
                    w_stateNext = bus.imem_ack_i ? S_FETCH : S_DRAIN;
                end else if (bus.imem_ack_i) begin
                    w_stateNext = S_VALID;
                end
            end
            S_VALID: begin
                if (bus.redirect_i || !bus.stall_i) begin
                    w_stateNext = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (bus.imem_ack_i) begin
                    w_stateNext = S_FETCH;
                end
            end
            default: w_stateNext = S_BOOT;
        endcase
    end

    // Every new fetch is issued at w_nextPc, which already reflects any redirect this cycle.
    always_comb begin
        w_reqNext    = r_req;
        w_addrNext   = r_addr;
        w_instNext   = r_inst;
        w_instPcNext = r_instPc;
        w_validNext  = r_valid;
        case (r_state)
            S_BOOT: begin
                w_reqNext  = 1'b1;
                w_addrNext = w_nextPc;
            end
            S_FETCH: begin
                if (bus.redirect_i) begin
                    if (bus.imem_ack_i) begin
                        w_addrNext = w_nextPc;
                    end
                end else if (bus.imem_ack_i) begin
                    w_instNext   = bus.imem_data_i;
                    w_instPcNext = r_addr;
                    w_validNext  = 1'b1;
                    w_reqNext    = 1'b0;
                end
            end
            S_VALID: begin
                if (bus.redirect_i || !bus.stall_i) begin
                    w_validNext = 1'b0;
                    w_reqNext   = 1'b1;
                    w_addrNext  = w_nextPc;
                end
            end
            S_DRAIN: begin
                if (bus.imem_ack_i) begin
                    w_addrNext = w_nextPc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc     <= RESET_PC;
            r_req    <= 1'b0;
            r_addr   <= 32'h0;
            r_inst   <= 32'h0;
            r_instPc <= 32'h0;
            r_valid  <= 1'b0;
            r_flush  <= 1'b0;
            r_trap   <= 1'b0;
        end else begin
            r_pc     <= w_nextPc;
            r_req    <= w_reqNext;
            r_addr   <= w_addrNext;
            r_inst   <= w_instNext;
            r_instPc <= w_instPcNext;
            r_valid  <= w_validNext;
            r_flush  <= bus.redirect_i;
            r_trap   <= w_trap;
        end
    end

    assign bus.imem_req_o   = r_req;
    assign bus.imem_addr_o  = r_addr;
    assign bus.inst_o       = r_inst;
    assign bus.inst_pc_o    = r_instPc;
    assign bus.inst_valid_o = r_valid;
    assign bus.flush_o      = r_flush;
    assign bus.trap_o       = r_trap;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random stimulus against an event-level model.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam logic [31:0] WRAP_RESET_PC = 32'hFFFF_FFFC;
`ifdef PC_SEQUENCER_PC_TRAP_EN
    localparam logic [31:0] TRAP_EXP_ADDR = 32'h0000_0080;
    localparam logic        TRAP_EXP_FLAG = 1'b1;
`else
    localparam logic [31:0] TRAP_EXP_ADDR = 32'h0000_0100;
    localparam logic        TRAP_EXP_FLAG = 1'b0;
`endif

    logic clk_i;
    logic rst_i;

    pc_sequencer_if busA ();
    pc_sequencer_if busW ();

    pc_sequencer dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (busA)
    );

    pc_sequencer #(.RESET_PC(WRAP_RESET_PC)) dutWrap (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (busW)
    );

    int assertCount = 0;
    int failCount   = 0;

    bit          mBoot, mReq, mDrop, mValid, mFlush, mTrap;
    logic [31:0] mPc, mAddr, mInst, mInstPc;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mBoot = 1'b1; mReq = 1'b0; mDrop = 1'b0; mValid = 1'b0; mFlush = 1'b0; mTrap = 1'b0;
        mPc = PC_RESET_DEFAULT; mAddr = 32'h0; mInst = 32'h0; mInstPc = 32'h0;
    endtask

    task automatic startFetch();
        mReq  = 1'b1;
        mAddr = mPc;
        mDrop = 1'b0;
    endtask

    // Event view: a redirect kills the held instruction and any outstanding data; otherwise
    // deliver on ack, or release the held instruction and fetch the next one when not stalled.
    task automatic modelStep(input bit stall, input bit redir, input logic [31:0] tgtRaw,
                             input bit ack, input logic [31:0] data);
        logic [31:0] tgt;
        bit          ackSeen;
`ifdef PC_SEQUENCER_PC_TRAP_EN
        bit misaligned;
        misaligned = (tgtRaw % 32'd4) != 32'd0;
        tgt        = misaligned ? PC_TRAP_VEC_DEFAULT : tgtRaw;
        mTrap      = redir && misaligned;
`else
        tgt   = tgtRaw - (tgtRaw % 32'd4);
        mTrap = 1'b0;
`endif
        ackSeen = ack && mReq;
        mFlush  = redir;
        if (redir) begin
            mPc    = tgt;
            mValid = 1'b0;
            if (!mReq || ackSeen) startFetch();
            else mDrop = 1'b1;
        end else if (mBoot) begin
            startFetch();
        end else if (ackSeen) begin
            if (mDrop) begin
                startFetch();
            end else begin
                mInst   = data;
                mInstPc = mAddr;
                mValid  = 1'b1;
                mReq    = 1'b0;
                mPc     = mAddr + 32'd4;
            end
        end else if (mValid && !stall) begin
            mValid = 1'b0;
            startFetch();
        end
        mBoot = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        checkBit({tag, ".req"},   busA.imem_req_o,   mReq);
        checkEq ({tag, ".addr"},  busA.imem_addr_o,  mAddr);
        checkEq ({tag, ".inst"},  busA.inst_o,       mInst);
        checkEq ({tag, ".pc"},    busA.inst_pc_o,    mInstPc);
        checkBit({tag, ".valid"}, busA.inst_valid_o, mValid);
        checkBit({tag, ".flush"}, busA.flush_o,      mFlush);
        checkBit({tag, ".trap"},  busA.trap_o,       mTrap);
    endtask

    task automatic applyStimulus(input string tag, input bit stall, input bit redir,
                                 input logic [31:0] tgt, input bit ack, input logic [31:0] data);
        busA.stall_i       = stall;
        busA.redirect_i    = redir;
        busA.redirect_pc_i = tgt;
        busA.imem_ack_i    = ack;
        busA.imem_data_i   = data;
        @(posedge clk_i);
        modelStep(stall, redir, tgt, ack, data);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        busA.stall_i = 1'b0; busA.redirect_i = 1'b0; busA.redirect_pc_i = 32'h0;
        busA.imem_ack_i = 1'b0; busA.imem_data_i = 32'h0;
        busW.stall_i = 1'b0; busW.redirect_i = 1'b0; busW.redirect_pc_i = 32'h0;
        busW.imem_ack_i = 1'b0; busW.imem_data_i = 32'h0;
        rst_i = 1'b1;
        #1 rst_i = 1'b0;
        #2;
        modelReset();
        checkOutput("reset");
        checkEq("wrapReset.addr", busW.imem_addr_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int k = 0; k < 8; k++) begin
            applyStimulus("zeroWait", 1'b0, 1'b0, 32'h0, 1'b1, $urandom);
            checkBit("zeroWait.validSeq", busA.inst_valid_o, (k % 2) == 1);
            if ((k % 2) == 1) checkEq("zeroWait.pcSeq", busA.inst_pc_o, 32'((k - 1) / 2 * 4));
        end

        applyStimulus("consume", 1'b0, 1'b0, 32'h0, 1'b0, $urandom);
        checkEq("consume.addr", busA.imem_addr_o, 32'h10);
        applyStimulus("pending", 1'b0, 1'b0, 32'h0, 1'b0, $urandom);
        rst_i = 1'b0;
        #1;
        checkBit("midReset.reqDrop", busA.imem_req_o, 1'b0);
        modelReset();
        checkOutput("midReset");
        @(negedge clk_i);
        rst_i = 1'b1;

        applyStimulus("boot", 1'b0, 1'b0, 32'h0, 1'b0, $urandom);
        for (int k = 0; k < 3; k++) begin
            applyStimulus("ackWait", 1'b0, 1'b0, 32'h0, 1'b0, $urandom);
            checkBit("ackWait.req", busA.imem_req_o, 1'b1);
            checkEq("ackWait.addr", busA.imem_addr_o, 32'h0);
        end
        applyStimulus("lateAck", 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0001);
        checkBit("lateAck.valid", busA.inst_valid_o, 1'b1);
        checkEq("lateAck.pc", busA.inst_pc_o, 32'h0);

        applyStimulus("toFour", 1'b0, 1'b0, 32'h0, 1'b0, $urandom);
        applyStimulus("ackFour", 1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        applyStimulus("toEight", 1'b0, 1'b0, 32'h0, 1'b0, $urandom);
        applyStimulus("ackEight", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0013);
        for (int k = 0; k < 4; k++) begin
            applyStimulus("stall", 1'b1, 1'b0, 32'h0, 1'b1, $urandom);
            checkEq("stall.inst", busA.inst_o, 32'h0000_0013);
            checkEq("stall.pc", busA.inst_pc_o, 32'h8);
            checkBit("stall.noReq", busA.imem_req_o, 1'b0);
        end
        applyStimulus("release", 1'b0, 1'b0, 32'h0, 1'b0, $urandom);
        checkEq("release.addr", busA.imem_addr_o, 32'hC);
        checkBit("release.req", busA.imem_req_o, 1'b1);

        applyStimulus("redirFetch", 1'b0, 1'b1, 32'h100, 1'b0, $urandom);
        checkBit("redirFetch.flush", busA.flush_o, 1'b1);
        checkEq("redirFetch.holdAddr", busA.imem_addr_o, 32'hC);
        applyStimulus("drainWait", 1'b0, 1'b0, 32'h0, 1'b0, $urandom);
        applyStimulus("drainAck", 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        checkBit("drainAck.dropped", busA.inst_valid_o, 1'b0);
        checkEq("drainAck.newAddr", busA.imem_addr_o, 32'h100);
        applyStimulus("targetAck", 1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        checkEq("targetAck.pc", busA.inst_pc_o, 32'h100);

        applyStimulus("redirStall", 1'b1, 1'b1, 32'h200, 1'b0, $urandom);
        checkBit("redirStall.valid", busA.inst_valid_o, 1'b0);
        checkEq("redirStall.addr", busA.imem_addr_o, 32'h200);

        applyStimulus("drainA", 1'b0, 1'b1, 32'h300, 1'b0, $urandom);
        applyStimulus("drainB", 1'b0, 1'b1, 32'h400, 1'b0, $urandom);
        checkBit("drainB.flush", busA.flush_o, 1'b1);
        applyStimulus("drainBAck", 1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        checkEq("drainBAck.addr", busA.imem_addr_o, 32'h400);

        applyStimulus("trapRedir", 1'b0, 1'b1, 32'h102, 1'b1, $urandom);
        checkEq("trapRedir.addr", busA.imem_addr_o, TRAP_EXP_ADDR);
        checkBit("trapRedir.trap", busA.trap_o, TRAP_EXP_FLAG);
        applyStimulus("trapAck", 1'b0, 1'b0, 32'h0, 1'b1, $urandom);
        checkEq("trapAck.pc", busA.inst_pc_o, TRAP_EXP_ADDR);

        for (int n = 0; n < 400; n++) begin
            applyStimulus("random", $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                          $urandom & 32'h0000_0FFF, $urandom_range(0, 1) == 1, $urandom);
        end

        checkBit("wrap.req", busW.imem_req_o, 1'b1);
        checkEq("wrap.firstAddr", busW.imem_addr_o, WRAP_RESET_PC);
        busW.imem_data_i = 32'h0000_0013;
        busW.imem_ack_i  = 1'b1;
        @(posedge clk_i); #1;
        checkBit("wrap.valid", busW.inst_valid_o, 1'b1);
        checkEq("wrap.instPc", busW.inst_pc_o, WRAP_RESET_PC);
        busW.imem_ack_i = 1'b0;
        @(posedge clk_i); #1;
        checkBit("wrap.req2", busW.imem_req_o, 1'b1);
        checkEq("wrap.secondAddr", busW.imem_addr_o, 32'h0);
        busW.imem_ack_i = 1'b1;
        @(posedge clk_i); #1;
        checkEq("wrap.secondPc", busW.inst_pc_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
